// File: rtl/au_request_scheduler.sv
// ---------------------------------------------------------------------------
// au_request_scheduler
//
// Shares one combinational arithmetic unit between two requesters. A
// round-robin arbiter picks one request at a time. Its operands are
// registered onto au_a/au_b/au_op. The AU outputs are then given
// SETTLE_CYCLES clock edges to settle before they are captured and returned
// on a response port together with the requester id.
//
// Handshake rules (both the request and response sides):
//   A transfer happens on a rising edge where valid & ready are both high.
//   A source keeps its payload stable while valid is high and ready is low.
//   reqN_ready is combinational and never depends on this block's outputs.
//   At most one reqN_ready is high in any cycle.
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_a/b/op           operands and op (00 add, 01 sub, 10 mul, 11 div)
//   au_a/au_b/au_op       registered operands driven to the AU
//   au_result/zero/ovf    AU outputs, sampled at the end of the settle window
//   rsp_valid/ready       response handshake
//   rsp_id/result/...     captured response payload
//   busy                  an operation is in flight (state != IDLE)
//   err_count             responses delivered with overflow, saturating at 255
// ---------------------------------------------------------------------------
module au_request_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic [1:0] au_op,
  input  logic [7:0] au_result,
  input  logic       au_zero,
  input  logic       au_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Settle counter preload: the capture happens on the edge where cnt is 0,
  // so a preload of SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES EXEC edges.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       sel;
  logic       rsp_done;

  // Round robin: a lone requester always wins; when both ask, the one that
  // was not granted last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    sel        = req1_ready;
    rsp_done   = rsp_valid & rsp_ready;
    busy       = (state != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = EXEC;
      EXEC:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand registers, settle counter, response capture, errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      cnt          <= 4'd0;
      au_a         <= 4'd0;
      au_b         <= 4'd0;
      au_op        <= 2'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 8'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            au_a       <= sel ? req1_a  : req0_a;
            au_b       <= sel ? req1_b  : req0_b;
            au_op      <= sel ? req1_op : req0_op;
            rsp_id     <= sel;
            last_grant <= sel;
            cnt        <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result   <= au_result;
            rsp_zero     <= au_zero;
            rsp_overflow <= au_overflow;
            rsp_valid    <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid <= 1'b0;
            if (rsp_overflow && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_au_request_scheduler
//
// Bench for au_request_scheduler with SETTLE_CYCLES = 3. A combinational
// arithmetic-unit model drives au_result/au_zero/au_overflow from the DUT's
// au_* outputs:
//   add: low nibble of a+b, overflow = carry out
//   sub: low nibble of a-b, overflow = borrow (a < b)
//   mul: 8-bit product, overflow = product > 15
//   div: {a % b, a / b}; divide by zero gives result 0 and overflow 1
//   zero = (result == 0)
// A transaction-level reference model tracks each operation from accept to
// response handshake and is compared with the DUT every cycle. Directed
// sequences pin the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_au_request_scheduler;

  localparam int SETTLE = 3;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic [3:0] au_a, au_b;
  logic [1:0] au_op;
  logic [7:0] au_result;
  logic       au_zero, au_overflow;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_overflow;
  logic       busy;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  au_request_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .au_a(au_a), .au_b(au_b), .au_op(au_op),
    .au_result(au_result), .au_zero(au_zero), .au_overflow(au_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .busy(busy), .err_count(err_count)
  );

  // ---------------- arithmetic unit model ----------------
  // Packed as {result[7:0], zero, overflow}.
  function automatic logic [9:0] au_fn(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    logic [7:0] r;
    logic       ovf;
    logic [4:0] s;
    r = 8'd0; ovf = 1'b0; s = 5'd0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = {4'd0, s[3:0]}; ovf = s[4]; end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; r = {4'd0, s[3:0]}; ovf = (a < b); end
      2'd2: begin r = {4'd0, a} * {4'd0, b}; ovf = (r > 8'd15); end
      default: begin
        if (b == 4'd0) begin r = 8'd0; ovf = 1'b1; end
        else begin r = {a % b, a / b}; ovf = 1'b0; end
      end
    endcase
    return {r, (r == 8'd0), ovf};
  endfunction

  always_comb {au_result, au_zero, au_overflow} = au_fn(au_a, au_b, au_op);

  // ---------------- reference model ----------------
  logic [9:0] exp_q[$];   // expected {result, zero, ovf} per accepted operation
  logic       m_busy, m_last, m_id, m_rv, m_zero, m_ovf;
  logic [3:0] m_a, m_b;
  logic [1:0] m_op;
  logic [7:0] m_res;
  int         m_age, m_err;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Applies one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int g;
    logic [9:0] e;
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_id = 0; m_rv = 0; m_zero = 0; m_ovf = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_age = 0; m_err = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      g = pick(req0_valid, req1_valid, m_last);
      if (g >= 0) begin
        m_a  = (g == 1) ? req1_a  : req0_a;
        m_b  = (g == 1) ? req1_b  : req0_b;
        m_op = (g == 1) ? req1_op : req0_op;
        m_id = (g == 1);
        m_last = (g == 1);
        m_busy = 1;
        m_age  = 0;
        exp_q.push_back(au_fn(m_a, m_b, m_op));
      end
    end else if (!m_rv) begin
      m_age++;
      if (m_age == SETTLE) begin
        e = exp_q.pop_front();
        {m_res, m_zero, m_ovf} = e;
        m_rv = 1;
      end
    end else if (rsp_ready) begin
      m_rv = 0;
      m_busy = 0;
      if (m_ovf && m_err < 255) m_err++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    int g;
    g = pick(req0_valid, req1_valid, m_last);
    chk("req0_ready", req0_ready, (!m_busy && g == 0));
    chk("req1_ready", req1_ready, (!m_busy && g == 1));
    chk("busy", busy, m_busy);
    chk("au_a", au_a, m_a);
    chk("au_b", au_b, m_b);
    chk("au_op", au_op, m_op);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", rsp_zero, m_zero);
    chk("rsp_overflow", rsp_overflow, m_ovf);
    chk("err_count", err_count, m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle_cmp();
    #1;
    compare_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic cyc();
    settle_cmp();
    edge_step();
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  // Issues one operation on requester `id` with rsp_ready held high and
  // returns the response seen on the port.
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, output logic [7:0] res,
                       output logic ovf, output logic rid);
    bit got;
    got = 0; res = 0; ovf = 0; rid = 0;
    rsp_ready = 1;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    for (int i = 0; i < 40 && !got; i++) begin
      settle_cmp();
      if (req0_ready || req1_ready) begin
        edge_step();
        idle_inputs();
      end else begin
        if (rsp_valid) begin
          res = rsp_result; ovf = rsp_overflow; rid = rsp_id; got = 1;
        end
        edge_step();
      end
    end
    if (!got) chk("do_op_timeout", 0, 1);
    idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] r_res;
  logic       r_ovf, r_id;
  int         grants[$];
  logic [7:0] t2_res[2];
  logic       t2_ovf[2], t2_id[2];
  int         n_rsp;
  int         exp_grant[4] = '{0, 1, 0, 1};
  bit         seen;

  initial begin
    idle_inputs();
    rsp_ready = 0;
    rst_n = 0;
    edge_step();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_au_a", au_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    cyc();
    rst_n = 1;
    cyc();

    // T1: single add 7+9 -> 0x00, zero, overflow
    rsp_ready = 1;
    req0_valid = 1; req0_a = 7; req0_b = 9; req0_op = 0;
    settle_cmp();
    chk("t1_ready0", req0_ready, 1);
    edge_step();
    idle_inputs();
    for (int i = 0; i < SETTLE; i++) begin
      settle_cmp();
      chk("t1_early_valid", rsp_valid, 0);
      edge_step();
    end
    settle_cmp();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_result", rsp_result, 8'h00);
    chk("t1_zero", rsp_zero, 1);
    chk("t1_ovf", rsp_overflow, 1);
    chk("t1_au_a", au_a, 7);
    edge_step();
    settle_cmp();
    chk("t1_err", err_count, 1);
    chk("t1_idle", busy, 0);

    // T2: both valid after reset, grants alternate starting with 0
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_op = 2;
    req1_valid = 1; req1_a = 2; req1_b = 5; req1_op = 1;
    rsp_ready = 1;
    n_rsp = 0;
    for (int i = 0; i < 80 && grants.size() < 4; i++) begin
      settle_cmp();
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid && n_rsp < 2) begin
        t2_res[n_rsp] = rsp_result; t2_ovf[n_rsp] = rsp_overflow; t2_id[n_rsp] = rsp_id;
        n_rsp++;
      end
      edge_step();
    end
    chk("t2_grant_count", grants.size(), 4);
    chk("t2_rsp_count", n_rsp, 2);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("t2_grant", grants[i], exp_grant[i]);
    chk("t2_id0", t2_id[0], 0);
    chk("t2_res0", t2_res[0], 8'h0F);
    chk("t2_ovf0", t2_ovf[0], 0);
    chk("t2_id1", t2_id[1], 1);
    chk("t2_res1", t2_res[1], 8'h0D);
    chk("t2_ovf1", t2_ovf[1], 1);

    // T3: backpressure with both requesters still asking
    rsp_ready = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      settle_cmp();
      if (rsp_valid) seen = 1;
      else edge_step();
    end
    chk("t3_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      edge_step();
      settle_cmp();
      chk("t3_ready0", req0_ready, 0);
      chk("t3_ready1", req1_ready, 0);
      chk("t3_busy", busy, 1);
      chk("t3_valid", rsp_valid, 1);
    end
    rsp_ready = 1;
    idle_inputs();
    edge_step();
    settle_cmp();
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_valid", rsp_valid, 0);

    // T4: divide
    do_reset();
    do_op(0, 13, 4, 3, r_res, r_ovf, r_id);
    chk("t4_div_res", r_res, 8'h13);
    chk("t4_div_ovf", r_ovf, 0);
    settle_cmp();
    chk("t4_err0", err_count, 0);
    do_op(1, 9, 0, 3, r_res, r_ovf, r_id);
    chk("t4_div0_ovf", r_ovf, 1);
    chk("t4_div0_id", r_id, 1);
    settle_cmp();
    chk("t4_err1", err_count, 1);

    // T5: reset mid-EXEC drops the operation
    req1_valid = 1; req1_a = 5; req1_b = 6; req1_op = 0;
    rsp_ready = 1;
    cyc();                  // accept
    idle_inputs();
    cyc();                  // one EXEC edge
    rst_n = 0;
    cyc();                  // reset edge
    rst_n = 1;
    settle_cmp();
    chk("t5_busy", busy, 0);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_au_a", au_a, 0);
    chk("t5_au_b", au_b, 0);
    chk("t5_id", rsp_id, 0);
    chk("t5_err", err_count, 0);
    req0_valid = 1; req1_valid = 1;
    settle_cmp();
    chk("t5_ready0", req0_ready, 1);
    chk("t5_ready1", req1_ready, 0);
    idle_inputs();
    for (int i = 0; i < SETTLE + 3; i++) cyc();

    // T6: err_count saturation
    do_reset();
    for (int i = 0; i < 260; i++) do_op(0, 15, 1, 0, r_res, r_ovf, r_id);
    settle_cmp();
    chk("t6_err_sat", err_count, 255);
    do_op(1, 15, 1, 0, r_res, r_ovf, r_id);
    settle_cmp();
    chk("t6_err_hold", err_count, 255);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      req0_valid = ($urandom_range(0, 99) < 45);
      req1_valid = ($urandom_range(0, 99) < 45);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      cyc();
    end
    rst_n = 1;
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
